// File: rtl/spi_reg_ctrl_pkg.sv
// Shared constants and FSM state type for the SPI configuration register block.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with registered rise/fall pulses.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 target holding the five pwm_peripheral configuration registers.
// Optional readback of the addressed register on cipo when SPI_READBACK_EN is defined.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_copi, w_unused_copi_rise, w_unused_copi_fall;
    logic w_ncs, w_ncs_rise, w_ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk),
        .o_q(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .i_d(copi),
        .o_q(w_copi), .o_rise(w_unused_copi_rise), .o_fall(w_unused_copi_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .i_d(ncs),
        .o_q(w_ncs), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    logic w_unused_levels;
    assign w_unused_levels = w_sclk ^ w_ncs;

    state_t      r_state, w_next;
    logic        w_clr, w_shift, w_check, w_valid;
    logic [15:0] r_sr;
    logic [4:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A fresh ncs fall always restarts the frame, even mid-SHIFT.
    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_shift = 1'b0;
        w_check = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ncs_fall) begin
                    w_clr  = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_ncs_fall)       w_clr   = 1'b1;
                else if (w_ncs_rise)  w_next  = CHECK;
                else if (w_sclk_rise) w_shift = 1'b1;
            end
            CHECK: begin
                w_check = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_clr) begin
            r_cnt <= '0;
        end else if (w_shift && r_cnt < CNT_SAT) begin
            if (r_cnt < CNT_FULL) r_sr <= {r_sr[14:0], w_copi};
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign w_valid = (r_cnt == CNT_FULL) && r_sr[15] && ({25'd0, r_sr[14:8]} <= MAX_ADDR);

    // Stage p1: the checked write is registered, then applied to the register file.
    logic       r_vld_p1;
    logic [6:0] r_addr_p1;
    logic [7:0] r_data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_addr_p1 <= '0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1  <= w_check && w_valid;
            r_addr_p1 <= r_sr[14:8];
            r_data_p1 <= r_sr[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (r_vld_p1) begin
            case (r_addr_p1)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= r_data_p1;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= r_data_p1;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= r_data_p1;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= r_data_p1;
                ADDR_DUTY:      pwm_duty_cycle  <= r_data_p1;
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic       r_load, r_tx_act;
    logic [7:0] r_tx, w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        if ({25'd0, r_sr[6:0]} <= MAX_ADDR) begin
            case (r_sr[6:0])
                ADDR_EN_OUT_LO: w_rd_data = en_reg_out_7_0;
                ADDR_EN_OUT_HI: w_rd_data = en_reg_out_15_8;
                ADDR_EN_PWM_LO: w_rd_data = en_reg_pwm_7_0;
                ADDR_EN_PWM_HI: w_rd_data = en_reg_pwm_15_8;
                ADDR_DUTY:      w_rd_data = pwm_duty_cycle;
                default:        w_rd_data = 8'h00;
            endcase
        end
    end

    // r_sr[7:0] holds R/W and address on the cycle after the 8th bit lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load   <= 1'b0;
            r_tx_act <= 1'b0;
            r_tx     <= 8'h00;
        end else begin
            r_load <= w_shift && (r_cnt == 5'd7);
            if (r_load && !r_sr[7]) begin
                r_tx     <= w_rd_data;
                r_tx_act <= 1'b1;
            end else if (r_tx_act && w_sclk_fall && r_cnt >= 5'd9) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
            if (r_state != SHIFT || w_ncs_rise || w_ncs_fall) r_tx_act <= 1'b0;
        end
    end

    assign cipo = r_tx_act & r_tx[7];
`else
    logic w_unused_sclk_fall;
    assign w_unused_sclk_fall = w_sclk_fall;
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: bit-banged SPI frames against a register model.
module tb_spi_reg_ctrl;

`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] o0, o1, o2, o3, o4;

    int total = 0;
    int bad = 0;

    logic [7:0]  m [5];
    logic [39:0] rq [$];
    logic        cq [$];

    always #5 clk = ~clk;

    spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(o0), .en_reg_out_15_8(o1), .en_reg_pwm_7_0(o2),
        .en_reg_pwm_15_8(o3), .pwm_duty_cycle(o4)
    );

    function automatic logic [39:0] model_pack();
        return {m[4], m[3], m[2], m[1], m[0]};
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        return (a <= 7'd4) ? m[a] : 8'h00;
    endfunction

    task automatic drive_bits(input logic [16:0] d, input int n, input int lo, input int hi,
                              input bit rd, input logic [7:0] rdexp);
        logic got, exp;
        for (int i = lo; i < hi; i++) begin
            copi = d[n-1-i];
            sclk = 1'b0;
            cq.push_back((RB && rd && i >= 8 && i < 16) ? rdexp[15-i] : 1'b0);
            repeat (4) @(negedge clk);
            exp = cq.pop_front();
            got = cipo;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL cipo_bit%0d: got %b expected %b", i, got, exp);
            end
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic end_frame(input logic [16:0] d, input int n, input bit may_commit);
        logic [39:0] old, exp, got;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        old = model_pack();
        if (may_commit && n == 16 && d[15] && d[14:8] <= 7'd4) m[d[14:8]] = d[7:0];
        rq.push_back(model_pack());
        repeat (4) @(negedge clk);
        got = {o4, o3, o2, o1, o0};
        total++;
        if (got !== old) begin
            bad++;
            $display("FAIL early_update: got %h expected %h", got, old);
        end
        @(negedge clk);
        exp = rq.pop_front();
        got = {o4, o3, o2, o1, o0};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL commit_%h: got %h expected %h", d, got, exp);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [16:0] d, input int n, input bit rd, input logic [7:0] rdexp);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        drive_bits(d, n, 0, n, rd, rdexp);
        end_frame(d, n, 1'b1);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({o4, o3, o2, o1, o0, cipo} !== 41'd0) begin
            bad++;
            $display("FAIL reset_hold: got %h expected 0", {o4, o3, o2, o1, o0, cipo});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        repeat (50) @(negedge clk);
        total++;
        if ({o4, o3, o2, o1, o0, cipo} !== 41'd0) begin
            bad++;
            $display("FAIL reset_idle: got %h expected 0", {o4, o3, o2, o1, o0, cipo});
        end
    endtask

    task automatic test_write_basic();
        spi_frame(17'h080F0, 16, 1'b0, 8'h00);
        total++;
        if (o0 !== 8'hF0) begin
            bad++;
            $display("FAIL en_out_lo: got %h expected f0", o0);
        end
    endtask

    task automatic test_duty_bad_addr();
        spi_frame(17'h08480, 16, 1'b0, 8'h00);
        spi_frame(17'h085AA, 16, 1'b0, 8'h00);
        total++;
        if (o4 !== 8'h80) begin
            bad++;
            $display("FAIL duty: got %h expected 80", o4);
        end
    endtask

    task automatic test_bad_length();
        spi_frame(17'h04109, 15, 1'b0, 8'h00);
        spi_frame(17'h106AB, 17, 1'b0, 8'h00);
        total++;
        if ({o3, o2} !== 16'h0000) begin
            bad++;
            $display("FAIL bad_length_pwm: got %h expected 0000", {o3, o2});
        end
    endtask

    task automatic test_readback();
        spi_frame(17'h0823C, 16, 1'b0, 8'h00);
        spi_frame(17'h00255, 16, 1'b1, 8'h3C);
        spi_frame(17'h00500, 16, 1'b1, 8'h00);
        total++;
        if (o2 !== 8'h3C) begin
            bad++;
            $display("FAIL read_keeps_reg: got %h expected 3c", o2);
        end
    endtask

    task automatic test_idle_sclk();
        logic [39:0] got;
        for (int i = 0; i < 16; i++) begin
            copi = 1'b1;
            sclk = ~sclk;
            repeat (4) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        got = {o4, o3, o2, o1, o0};
        total++;
        if (got !== model_pack()) begin
            bad++;
            $display("FAIL idle_sclk: got %h expected %h", got, model_pack());
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] d;
        for (int k = 0; k < 8; k++) begin
            d = {1'b0, 1'($urandom_range(0, 1)), 4'd0, 3'($urandom_range(0, 6)), 8'($urandom)};
            spi_frame(d, 16, !d[15], model_read(d[14:8]));
        end
    endtask

    task automatic test_reset_midframe();
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        drive_bits(17'h081FF, 16, 0, 9, 1'b0, 8'h00);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        @(negedge clk);
        total++;
        if ({o4, o3, o2, o1, o0, cipo} !== 41'd0) begin
            bad++;
            $display("FAIL midframe_reset: got %h expected 0", {o4, o3, o2, o1, o0, cipo});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        drive_bits(17'h081FF, 16, 9, 16, 1'b0, 8'h00);
        end_frame(17'h081FF, 16, 1'b0);
        spi_frame(17'h081A5, 16, 1'b0, 8'h00);
        total++;
        if (o1 !== 8'hA5) begin
            bad++;
            $display("FAIL post_reset_write: got %h expected a5", o1);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_duty_bad_addr();
        test_bad_length();
        test_readback();
        test_idle_sclk();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
